// File: rtl/audio_mix_pkg.sv
// audio_mix_pkg: shared FSM state type, unity gain constant and saturation helper for the audio mixer.
package audio_mix_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCALE = 2'd2,
    ST_OUT   = 2'd3
  } mix_state_t;
  localparam int DEF_GAIN_WIDTH = 8;
  localparam int UNITY_GAIN = 2 ** (DEF_GAIN_WIDTH - 1);
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/audio_output_mixer_gain_ramp.sv
// gain_ramp: per-source current gain that moves toward its target by at most RAMP_STEP per step strobe.
module gain_ramp #(
  parameter int GAIN_WIDTH = 8,
  parameter int RAMP_STEP  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step,
  input  logic [GAIN_WIDTH-1:0] target,
  output logic [GAIN_WIDTH-1:0] gain
);
  localparam logic [GAIN_WIDTH-1:0] STEP = GAIN_WIDTH'(RAMP_STEP);
  logic [GAIN_WIDTH-1:0] next;
  // differences are taken in the safe direction so the clamp never wraps
  always_comb
    next = gain < target ? (target - gain <= STEP ? target : gain + STEP)
         : gain > target ? (gain - target <= STEP ? target : gain - STEP)
         : gain;
  always_ff @(posedge clk)
    if (rst) gain <= '0;
    else if (step) gain <= next;
endmodule

// File: rtl/audio_output_mixer.sv
// audio_output_mixer: N-source ramped-gain mixer, one MAC per cycle, saturated with DC offset for the PDM stage.
module audio_output_mixer
  import audio_mix_pkg::*;
#(
  parameter int NUM_SRC    = 8,
  parameter int WIDTH      = 16,
  parameter int GAIN_WIDTH = 8,
  parameter int RAMP_STEP  = 4,
  parameter int OUT_OFFSET = 0
) (
  input  logic                          audio_clk,
  input  logic                          rst_in,
  input  logic                          sample_valid_in,
  input  logic [NUM_SRC*WIDTH-1:0]      src_in,
  input  logic [NUM_SRC-1:0]            src_enable_in,
  input  logic [NUM_SRC*GAIN_WIDTH-1:0] gain_in,
  input  logic                          mute_in,
  output logic signed [WIDTH-1:0]       mix_out,
  output logic                          mix_valid_out,
  output logic                          clip_out,
  output logic                          overrun_out,
  output logic                          busy_out
);
  localparam int ACC_W = WIDTH + GAIN_WIDTH + $clog2(NUM_SRC) + 1;
  localparam int IDX_W = $clog2(NUM_SRC);
  mix_state_t state;
  logic [IDX_W-1:0] idx;
  logic [NUM_SRC*WIDTH-1:0] snap;
  logic [GAIN_WIDTH-1:0] gain [NUM_SRC];
  logic signed [ACC_W-1:0] acc;
  logic step;
  logic signed [WIDTH-1:0] cur_src;
  logic [GAIN_WIDTH-1:0] cur_gain;
  logic signed [WIDTH+GAIN_WIDTH:0] prod;
  logic signed [63:0] scaled, sat1, sum2, sat2;
  logic signed [WIDTH-1:0] res;
  logic res_clip;
  assign busy_out = state != ST_IDLE;
  assign step = sample_valid_in && !busy_out;
  assign overrun_out = sample_valid_in && busy_out;
  genvar i;
  generate
    for (i = 0; i < NUM_SRC; i++) begin : g_ch
      gain_ramp #(.GAIN_WIDTH(GAIN_WIDTH), .RAMP_STEP(RAMP_STEP)) u_ramp (
        .clk   (audio_clk),
        .rst   (rst_in),
        .step  (step),
        .target(src_enable_in[i] && !mute_in ? gain_in[i*GAIN_WIDTH +: GAIN_WIDTH] : '0),
        .gain  (gain[i])
      );
    end
  endgenerate
  // gain is zero-extended so values up to 2**GAIN_WIDTH-1 stay positive
  always_comb begin
    cur_src  = $signed(snap[idx*WIDTH +: WIDTH]);
    cur_gain = gain[idx];
    prod     = cur_src * $signed({1'b0, cur_gain});
    scaled   = 64'(acc >>> (GAIN_WIDTH - 1));
    sat1     = sat_to_width(scaled, WIDTH);
    sum2     = sat1 + 64'(OUT_OFFSET);
    sat2     = sat_to_width(sum2, WIDTH);
  end
  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      state         <= ST_IDLE;
      idx           <= '0;
      acc           <= '0;
      snap          <= '0;
      res           <= '0;
      res_clip      <= 1'b0;
      mix_out       <= '0;
      clip_out      <= 1'b0;
      mix_valid_out <= 1'b0;
    end else begin
      mix_valid_out <= 1'b0;
      case (state)
        ST_IDLE:
          if (sample_valid_in) begin
            snap  <= src_in;
            acc   <= '0;
            idx   <= '0;
            state <= ST_ACCUM;
          end
        ST_ACCUM: begin
          acc <= acc + ACC_W'(prod);
          idx <= idx + IDX_W'(1);
          if (idx == IDX_W'(NUM_SRC - 1)) state <= ST_SCALE;
        end
        ST_SCALE: begin
          res      <= sat2[WIDTH-1:0];
          res_clip <= (sat1 != scaled) || (sat2 != sum2);
          state    <= ST_OUT;
        end
        default: begin
          mix_out       <= res;
          clip_out      <= res_clip;
          mix_valid_out <= 1'b1;
          state         <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_audio_output_mixer.sv
// tb_audio_output_mixer: directed checks of ramp, saturation, crossfade, overrun, offset and reset on the mixer.
module tb_audio_output_mixer;
  import audio_mix_pkg::*;
  localparam int N = 8, W = 16, GW = 8, LAT = N + 3;
  logic audio_clk = 1'b0;
  logic rst_in = 1'b1, sample_valid_in = 1'b0, mute_in = 1'b0;
  logic [N*W-1:0] src_in = '0;
  logic [N-1:0] src_enable_in = '0;
  logic [N*GW-1:0] gain_in = '0;
  logic signed [W-1:0] mix_a, mix_b;
  logic valid_a, valid_b, clip_a, clip_b, ovr_a, ovr_b, busy_a, busy_b;
  int checks = 0, passed = 0;

  audio_output_mixer #(.NUM_SRC(N), .WIDTH(W), .GAIN_WIDTH(GW), .RAMP_STEP(4), .OUT_OFFSET(0)) dut (
    .audio_clk(audio_clk), .rst_in(rst_in), .sample_valid_in(sample_valid_in), .src_in(src_in),
    .src_enable_in(src_enable_in), .gain_in(gain_in), .mute_in(mute_in), .mix_out(mix_a),
    .mix_valid_out(valid_a), .clip_out(clip_a), .overrun_out(ovr_a), .busy_out(busy_a));
  audio_output_mixer #(.NUM_SRC(N), .WIDTH(W), .GAIN_WIDTH(GW), .RAMP_STEP(4), .OUT_OFFSET(2000)) dut_off (
    .audio_clk(audio_clk), .rst_in(rst_in), .sample_valid_in(sample_valid_in), .src_in(src_in),
    .src_enable_in(src_enable_in), .gain_in(gain_in), .mute_in(mute_in), .mix_out(mix_b),
    .mix_valid_out(valid_b), .clip_out(clip_b), .overrun_out(ovr_b), .busy_out(busy_b));

  always #5 audio_clk = ~audio_clk;

  task automatic set_src(input int i, input int v);
    src_in[i*W +: W] = W'(v);
  endtask

  task automatic set_gain(input int i, input int g);
    gain_in[i*GW +: GW] = GW'(g);
  endtask

  task automatic do_reset();
    @(negedge audio_clk);
    rst_in = 1'b1;
    sample_valid_in = 1'b0;
    mute_in = 1'b0;
    src_in = '0;
    src_enable_in = '0;
    gain_in = '0;
    @(negedge audio_clk);
    @(negedge audio_clk);
    rst_in = 1'b0;
  endtask

  // strobe once and wait (bounded) for the result; lat counts cycles from strobe to valid
  task automatic do_sample(output int lat);
    @(negedge audio_clk);
    sample_valid_in = 1'b1;
    @(negedge audio_clk);
    sample_valid_in = 1'b0;
    lat = 1;
    while (!valid_a && lat < 40) begin
      @(negedge audio_clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mix_a !== '0) $display("FAIL reset_mix got %0d want 0", mix_a); else passed++;
    checks++; if (valid_a !== 1'b0) $display("FAIL reset_valid got %b want 0", valid_a); else passed++;
    checks++; if (clip_a !== 1'b0) $display("FAIL reset_clip got %b want 0", clip_a); else passed++;
    checks++; if (ovr_a !== 1'b0) $display("FAIL reset_overrun got %b want 0", ovr_a); else passed++;
    checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_a); else passed++;
  endtask

  task automatic test_ramp_pos();
    int lat, exp_v;
    int tab[4] = '{31, 62, 93, 125};
    do_reset();
    set_src(0, 1000);
    set_gain(0, UNITY_GAIN);
    src_enable_in = 8'h01;
    for (int k = 1; k <= 33; k++) begin
      do_sample(lat);
      if (k == 1) begin
        checks++; if (lat != LAT) $display("FAIL ramp_latency got %0d want %0d", lat, LAT); else passed++;
      end
      if (k <= 4 || k >= 32) begin
        exp_v = k <= 4 ? tab[k-1] : 1000;
        checks++; if (mix_a !== W'(exp_v)) $display("FAIL ramp_pos_k%0d got %0d want %0d", k, mix_a, exp_v); else passed++;
        checks++; if (clip_a !== 1'b0) $display("FAIL ramp_pos_clip_k%0d got %b want 0", k, clip_a); else passed++;
      end
    end
    mute_in = 1'b1;
    do_sample(lat);
    checks++; if (mix_a !== W'(968)) $display("FAIL mute_ramp got %0d want 968", mix_a); else passed++;
  endtask

  task automatic test_ramp_neg();
    int lat, exp_v;
    int tab[4] = '{-32, -63, -94, -125};
    do_reset();
    set_src(0, -1000);
    set_gain(0, UNITY_GAIN);
    src_enable_in = 8'h01;
    for (int k = 1; k <= 32; k++) begin
      do_sample(lat);
      if (k <= 4 || k == 32) begin
        exp_v = k <= 4 ? tab[k-1] : -1000;
        checks++; if (mix_a !== W'(exp_v)) $display("FAIL ramp_neg_k%0d got %0d want %0d", k, mix_a, exp_v); else passed++;
      end
    end
  endtask

  task automatic test_saturation();
    int lat;
    do_reset();
    set_src(0, 30000);
    set_src(1, 30000);
    set_gain(0, UNITY_GAIN);
    set_gain(1, UNITY_GAIN);
    src_enable_in = 8'h03;
    for (int k = 1; k <= 32; k++) do_sample(lat);
    checks++; if (mix_a !== 16'sh7fff) $display("FAIL sat_pos got %0d want 32767", mix_a); else passed++;
    checks++; if (clip_a !== 1'b1) $display("FAIL sat_pos_clip got %b want 1", clip_a); else passed++;
    set_src(0, -30000);
    set_src(1, -30000);
    do_sample(lat);
    checks++; if (mix_a !== 16'sh8000) $display("FAIL sat_neg got %0d want -32768", mix_a); else passed++;
    checks++; if (clip_a !== 1'b1) $display("FAIL sat_neg_clip got %b want 1", clip_a); else passed++;
    checks++; if (mix_b !== W'(-30768)) $display("FAIL sat_neg_offset got %0d want -30768", mix_b); else passed++;
    checks++; if (clip_b !== 1'b1) $display("FAIL sat_neg_offset_clip got %b want 1", clip_b); else passed++;
  endtask

  task automatic test_crossfade();
    int lat;
    do_reset();
    set_src(0, 500);
    set_src(3, 500);
    set_gain(0, UNITY_GAIN);
    set_gain(3, UNITY_GAIN);
    src_enable_in = 8'h01;
    for (int k = 1; k <= 32; k++) do_sample(lat);
    checks++; if (mix_a !== W'(500)) $display("FAIL xfade_steady got %0d want 500", mix_a); else passed++;
    src_enable_in = 8'h08;
    for (int k = 1; k <= 33; k++) begin
      do_sample(lat);
      checks++; if (mix_a !== W'(500)) $display("FAIL xfade_k%0d got %0d want 500", k, mix_a); else passed++;
    end
    set_src(0, 0);
    do_sample(lat);
    checks++; if (mix_a !== W'(500)) $display("FAIL xfade_src0_gone got %0d want 500", mix_a); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat, pulses = 0, at = 0;
    do_reset();
    set_src(0, 1000);
    set_gain(0, UNITY_GAIN);
    src_enable_in = 8'h01;
    @(negedge audio_clk);
    sample_valid_in = 1'b1;
    @(negedge audio_clk);
    sample_valid_in = 1'b0;
    @(negedge audio_clk);
    @(negedge audio_clk);
    sample_valid_in = 1'b1;
    #1;
    checks++; if (ovr_a !== 1'b1) $display("FAIL overrun_pulse got %b want 1", ovr_a); else passed++;
    checks++; if (busy_a !== 1'b1) $display("FAIL overrun_busy got %b want 1", busy_a); else passed++;
    @(negedge audio_clk);
    sample_valid_in = 1'b0;
    #1;
    checks++; if (ovr_a !== 1'b0) $display("FAIL overrun_single got %b want 0", ovr_a); else passed++;
    for (int n = 5; n <= 30; n++) begin
      @(negedge audio_clk);
      if (valid_a) begin
        pulses++;
        at = n;
      end
    end
    checks++; if (pulses != 1) $display("FAIL b2b_pulses got %0d want 1", pulses); else passed++;
    checks++; if (at != LAT) $display("FAIL b2b_latency got %0d want %0d", at, LAT); else passed++;
    checks++; if (mix_a !== W'(31)) $display("FAIL b2b_mix got %0d want 31", mix_a); else passed++;
    do_sample(lat);
    checks++; if (mix_a !== W'(62)) $display("FAIL b2b_next got %0d want 62", mix_a); else passed++;
  endtask

  task automatic test_offset();
    int lat;
    do_reset();
    set_src(0, 32000);
    set_gain(0, UNITY_GAIN);
    src_enable_in = 8'h01;
    do_sample(lat);
    checks++; if (mix_b !== W'(3000)) $display("FAIL offset_first got %0d want 3000", mix_b); else passed++;
    checks++; if (clip_b !== 1'b0) $display("FAIL offset_first_clip got %b want 0", clip_b); else passed++;
    for (int k = 2; k <= 32; k++) do_sample(lat);
    checks++; if (mix_b !== 16'sh7fff) $display("FAIL offset_sat got %0d want 32767", mix_b); else passed++;
    checks++; if (clip_b !== 1'b1) $display("FAIL offset_sat_clip got %b want 1", clip_b); else passed++;
    checks++; if (mix_a !== W'(32000)) $display("FAIL nooffset got %0d want 32000", mix_a); else passed++;
    checks++; if (clip_a !== 1'b0) $display("FAIL nooffset_clip got %b want 0", clip_a); else passed++;
  endtask

  task automatic test_reset_mid();
    int lat, pulses = 0;
    do_reset();
    set_src(0, 1000);
    set_gain(0, UNITY_GAIN);
    src_enable_in = 8'h01;
    @(negedge audio_clk);
    sample_valid_in = 1'b1;
    @(negedge audio_clk);
    sample_valid_in = 1'b0;
    @(negedge audio_clk);
    rst_in = 1'b1;
    @(negedge audio_clk);
    rst_in = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge audio_clk);
      if (valid_a) pulses++;
    end
    checks++; if (pulses != 0) $display("FAIL rst_mid_pulses got %0d want 0", pulses); else passed++;
    checks++; if (mix_a !== '0) $display("FAIL rst_mid_mix got %0d want 0", mix_a); else passed++;
    checks++; if (busy_a !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", busy_a); else passed++;
    do_sample(lat);
    checks++; if (lat != LAT) $display("FAIL rst_mid_latency got %0d want %0d", lat, LAT); else passed++;
    checks++; if (mix_a !== W'(31)) $display("FAIL rst_mid_ramp got %0d want 31", mix_a); else passed++;
  endtask

  initial begin
    test_reset();
    test_ramp_pos();
    test_ramp_neg();
    test_saturation();
    test_crossfade();
    test_back_to_back();
    test_offset();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
